mem_bus_arbiter: RTL and testbench

Two-master arbiter that shares the single-port synchronous main RAM between the bird CPU bus wrapper (master 0) and a secondary requester such as DMA or a display fetch (master 1). Each master uses a req/gnt/rvalid handshake. The arbiter latches the winning request, issues exactly one memory access, and returns read data through a registered response. It sits between the masters and the RAM and is the only driver of the RAM address, write-data and write-enable lines.

---
 rtl/mem_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Two-master req/gnt/rvalid arbiter in front of a single-port sync RAM.
// Revision : 1.0
// ============================================================================
module mem_bus_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int MODE         = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    state_t        state_q, state_d;
    logic          win_q, win_d;
    logic          we_q, we_d;
    logic          last_grant_q, last_grant_d;
    logic [3:0]    starve_cnt_q, starve_cnt_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          m0_rvalid_q, m0_rvalid_d;
    logic          m1_rvalid_q, m1_rvalid_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;
    logic          w_pick_m1;

    // Winner selection; only consulted in IDLE when at least one master requests.
    always_comb begin
        w_pick_m1 = m1_req;
        if (m0_req && m1_req) begin
            if (MODE == 0) begin
                w_pick_m1 = ~last_grant_q;
            end else begin
                w_pick_m1 = (starve_cnt_q == c_starve_limit);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        we_d         = we_q;
        last_grant_d = last_grant_q;
        starve_cnt_d = starve_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m0_rvalid_d  = 1'b0;
        m1_rvalid_d  = 1'b0;
        m0_gnt       = 1'b0;
        m1_gnt       = 1'b0;
        mem_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    win_d        = w_pick_m1;
                    we_d         = w_pick_m1 ? m1_we    : m0_we;
                    mem_addr_d   = w_pick_m1 ? m1_addr  : m0_addr;
                    mem_wdata_d  = w_pick_m1 ? m1_wdata : m0_wdata;
                    last_grant_d = w_pick_m1;
                    if (MODE == 1) begin
                        if (w_pick_m1) begin
                            starve_cnt_d = 4'd0;
                        end else if (m1_req && (starve_cnt_q != c_starve_limit)) begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                m0_gnt  = ~win_q;
                m1_gnt  = win_q;
                mem_we  = we_q;
                state_d = we_q ? IDLE : RESP;
            end
            RESP: begin
                // RAM data is valid now, one cycle after the address was presented.
                if (win_q) begin
                    m1_rdata_d  = mem_rdata;
                    m1_rvalid_d = 1'b1;
                end else begin
                    m0_rdata_d  = mem_rdata;
                    m0_rvalid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            win_q        <= 1'b0;
            we_q         <= 1'b0;
            last_grant_q <= 1'b1;
            starve_cnt_q <= 4'd0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            m0_rvalid_q  <= 1'b0;
            m1_rvalid_q  <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            we_q         <= we_d;
            last_grant_q <= last_grant_d;
            starve_cnt_q <= starve_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            m0_rvalid_q  <= m0_rvalid_d;
            m1_rvalid_q  <= m1_rvalid_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Scoreboard bench for mem_bus_arbiter (MODE 0 and MODE 1 instances).
// Revision : 1.0
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
    logic [15:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        m0_gnt1, m0_rvalid1, m1_gnt1, m1_rvalid1, mem_we1;
    logic [15:0] m0_rdata1, m1_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    logic [15:0] ram0 [0:65535];
    logic [15:0] ram1 [0:65535];
    logic [15:0] sh   [0:65535];

    typedef struct {
        int          cyc;
        bit          m;
        bit          we;
        logic [15:0] addr;
        logic [15:0] data;
        int          starve;
    } ev_t;

    ev_t gq0[$];
    ev_t rq0[$];
    ev_t gq1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk1     = 1'b0;

    mem_bus_arbiter #(.AW(16), .DW(16), .MODE(0), .STARVE_LIMIT(4)) u_dut0 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    mem_bus_arbiter #(.AW(16), .DW(16), .MODE(1), .STARVE_LIMIT(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt1), .m0_rvalid(m0_rvalid1), .m0_rdata(m0_rdata1),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt1), .m1_rvalid(m1_rvalid1), .m1_rdata(m1_rdata1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_rdata(mem_rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_we) ram0[mem_addr] <= mem_wdata;
        mem_rdata <= ram0[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_we1) ram1[mem_addr1] <= mem_wdata1;
        mem_rdata1 <= ram1[mem_addr1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic ev_t mk_ev(input int c, input bit m, input bit we,
                                  input logic [15:0] addr, input logic [15:0] data,
                                  input int starve);
        ev_t e;
        e.cyc = c; e.m = m; e.we = we; e.addr = addr; e.data = data; e.starve = starve;
        return e;
    endfunction

    // MODE 0 instance: grant and response scoreboards, plus idle write-enable check.
    always @(negedge clk) begin
        ev_t e;
        if (m0_gnt || m1_gnt) begin
            check("gnt_onehot", 32'(m0_gnt & m1_gnt), 32'd0);
            if (gq0.size() == 0) begin
                check("gnt_unexpected", 32'd1, 32'd0);
            end else begin
                e = gq0.pop_front();
                check("gnt_cycle", 32'(cyc), 32'(e.cyc));
                check("gnt_master", 32'(m1_gnt), 32'(e.m));
                check("gnt_we", 32'(mem_we), 32'(e.we));
                check("gnt_addr", 32'(mem_addr), 32'(e.addr));
                if (e.we) check("gnt_wdata", 32'(mem_wdata), 32'(e.data));
            end
        end else begin
            check("we_idle", 32'(mem_we), 32'd0);
        end
        if (m0_rvalid || m1_rvalid) begin
            check("rv_onehot", 32'(m0_rvalid & m1_rvalid), 32'd0);
            if (rq0.size() == 0) begin
                check("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                e = rq0.pop_front();
                check("rv_cycle", 32'(cyc), 32'(e.cyc));
                check("rv_master", 32'(m1_rvalid), 32'(e.m));
                check("rv_data", 32'(e.m ? m1_rdata : m0_rdata), 32'(e.data));
            end
        end
    end

    // MODE 1 instance: grant order and starvation counter.
    always @(negedge clk) begin
        ev_t e1;
        if (chk1 && (m0_gnt1 || m1_gnt1)) begin
            if (gq1.size() == 0) begin
                check("gnt1_unexpected", 32'd1, 32'd0);
            end else begin
                e1 = gq1.pop_front();
                check("gnt1_cycle", 32'(cyc), 32'(e1.cyc));
                check("gnt1_master", 32'(m1_gnt1), 32'(e1.m));
                check("starve_cnt", 32'(u_dut1.starve_cnt_q), 32'(e1.starve));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks();
        check("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
        check("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
    endtask

    task automatic set_req(input bit m, input bit req, input bit we,
                           input logic [15:0] addr, input logic [15:0] wd);
        if (m) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd;
        end
    endtask

    // One complete access on an idle arbiter; returns when the next access may start.
    task automatic access(input bit m, input bit we, input logic [15:0] addr, input logic [15:0] wd);
        int c = cyc;
        set_req(m, 1'b1, we, addr, wd);
        gq0.push_back(mk_ev(c + 1, m, we, addr, wd, 0));
        if (we) sh[addr] = wd;
        else    rq0.push_back(mk_ev(c + 3, m, 1'b0, addr, sh[addr], 0));
        tick();
        tick();
        set_req(m, 1'b0, 1'b0, addr, wd);
        if (!we) tick();
    endtask

    initial begin
        int c;
        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        tick();
        reset_checks();
        rst = 1'b0;

        // Write then read back on master 0.
        access(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        access(1'b0, 1'b0, 16'h0010, 16'h0000);

        // Master 1 read result must survive a later master 0 read.
        access(1'b0, 1'b1, 16'h0020, 16'h1234);
        access(1'b1, 1'b1, 16'h0030, 16'h5555);
        access(1'b1, 1'b0, 16'h0020, 16'h0000);
        access(1'b0, 1'b0, 16'h0030, 16'h0000);
        check("m1_rdata_hold", 32'(m1_rdata), 32'h1234);
        check("m0_rdata_val", 32'(m0_rdata), 32'h5555);

        // Reset during the ISSUE cycle of a write.
        c = cyc;
        set_req(1'b0, 1'b1, 1'b1, 16'h0040, 16'hAAAA);
        gq0.push_back(mk_ev(c + 1, 1'b0, 1'b1, 16'h0040, 16'hAAAA, 0));
        sh[16'h0040] = 16'hAAAA;
        tick();
        rst = 1'b1;
        tick();
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        reset_checks();
        tick();
        rst = 1'b0;

        // Reset during the ISSUE cycle of a read: its rvalid must never appear.
        c = cyc;
        set_req(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0);
        gq0.push_back(mk_ev(c + 1, 1'b0, 1'b0, 16'h0030, 16'h0, 0));
        tick();
        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        rst = 1'b0;
        check("abort_rdata", 32'(m0_rdata), 32'd0);
        tick();
        tick();

        // Tie after reset: m0 write wins, m1 read follows two cycles later.
        c = cyc;
        set_req(1'b0, 1'b1, 1'b1, 16'h0050, 16'h0A0A);
        set_req(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        sh[16'h0050] = 16'h0A0A;
        gq0.push_back(mk_ev(c + 1, 1'b0, 1'b1, 16'h0050, 16'h0A0A, 0));
        gq0.push_back(mk_ev(c + 3, 1'b1, 1'b0, 16'h0010, 16'h0000, 0));
        rq0.push_back(mk_ev(c + 5, 1'b1, 1'b0, 16'h0010, sh[16'h0010], 0));
        tick();
        tick();
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        tick();
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        tick();
        check("m0_rdata_after_rst", 32'(m0_rdata), 32'd0);

        // Both masters reading continuously: round-robin vs. starvation-guarded priority.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        c = cyc;
        set_req(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0);
        set_req(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0);
        chk1 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bit mm;
            bit m1w;
            mm  = k[0];
            m1w = ((k % 5) == 4);
            gq0.push_back(mk_ev(c + 1 + 3 * k, mm, 1'b0, mm ? 16'h0020 : 16'h0030, 16'h0, 0));
            rq0.push_back(mk_ev(c + 3 + 3 * k, mm, 1'b0, 16'h0,
                                mm ? sh[16'h0020] : sh[16'h0030], 0));
            gq1.push_back(mk_ev(c + 1 + 3 * k, m1w, 1'b0, 16'h0, 16'h0, m1w ? 0 : (k % 5) + 1));
        end
        repeat (29) tick();
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (4) tick();
        chk1 = 1'b0;

        check("gq0_drained", 32'(gq0.size()), 32'd0);
        check("rq0_drained", 32'(rq0.size()), 32'd0);
        check("gq1_drained", 32'(gq1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
